pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register with a valid/ready handshake on both sides and synchronous flush.
- A 2-entry skid buffer registers in_ready, so no combinational ready path crosses stages.
- Used between RV32IC pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); a flush injects a bubble carrying FLUSH_VALUE.
- SKID_EN=0 degrades the block to a plain stall register.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, out_data value after rst.
- FLUSH_VALUE, {WIDTH{1'b0}}, out_data value after flush (IF/ID instance uses RV32 NOP 32'h0000_0013).
- SKID_EN, 1, 1 = skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  downstream payload.
- occupancy  output  2  entries held: 0, 1 or 2 (debug/perf).

Behaviour:
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
  - in_data is ignored when no input transfer occurs.
- Reset (async, any time, including mid-transfer): out_valid=0, out_data=RESET_VALUE, skid entry invalid, occupancy=0, in_ready=1.
  - First edge after rst deasserts behaves as EMPTY.
- Storage: main register (drives out_data/out_valid) and skid register (SKID_EN=1 only).
- State machine (SKID_EN=1), encoded from the two valid bits:
  - EMPTY: occupancy=0, in_ready=1.
    - in_valid -> main<=in_data, go to BUSY.
    - Otherwise stay.
  - BUSY: occupancy=1, in_ready=1.
    - out_ready & in_valid -> main<=in_data, stay.
    - out_ready & !in_valid -> go to EMPTY.
    - !out_ready & in_valid -> skid<=in_data, go to FULL.
    - Neither -> hold.
  - FULL: occupancy=2, in_ready=0; inputs ignored.
    - out_ready -> main<=skid, go to BUSY.
    - Otherwise hold.
- in_ready is a flop output in SKID_EN=1, asserted in EMPTY/BUSY.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Input transfer -> main<=in_data, out_valid<=1.
  - Output transfer without input transfer -> out_valid<=0.
  - Occupancy is 0 or 1 only.
- Latency: 1 cycle from input transfer to out_valid in EMPTY. Throughput: 1 transfer/cycle sustained in both modes.
- Ordering: strict FIFO order. No payload is dropped or duplicated except by flush.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged.
- Flush (priority over all handshakes):
  - Next edge: out_valid=0, skid invalid, out_data=FLUSH_VALUE, occupancy=0, in_ready=1.
  - An input offered in the flush cycle is discarded, even if in_ready=1.
  - flush held multiple cycles keeps the stage EMPTY.
- out_data while out_valid=0: holds its last loaded value (RESET_VALUE, FLUSH_VALUE, or last payload). No X.
- Simultaneous rst and flush: rst wins, so out_data=RESET_VALUE.

Decomposition:
- Shared package pipe_pkg:
  - State typedef: EMPTY=2'b00, BUSY=2'b01, FULL=2'b11.
  - Constant RV32_NOP=32'h0000_0013.
  - Occupancy width constant.
- One sub-module pipe_data_reg: WIDTH-bit register with load enable, async active-high reset to RESET_VALUE, and synchronous load of FLUSH_VALUE. Instantiated for main and skid.

Test Plan:
- Reset: rst=1 mid-stream with occupancy=2 -> same cycle out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE. After release, in_data=32'hA5A5_0001 with in_valid=1 -> out_valid=1, out_data=32'hA5A5_0001 next cycle.
- Streaming: out_ready=1, in_valid=1, data 1..100 on consecutive cycles -> out_data 1..100 on consecutive cycles, 1-cycle lag, occupancy=1 throughout.
- Backpressure:
  - Send 0x10 then 0x20 with out_ready=0 -> occupancy=2, in_ready=0 at cycle 3, 0x30 offered is not accepted.
  - Then out_ready=1 -> outputs 0x10, 0x20, 0x30 in order, none lost.
- Flush: FLUSH_VALUE=32'h0000_0013, occupancy=2, flush=1 with in_valid=1/in_data=0x55 -> next cycle out_valid=0, out_data=32'h0000_0013, occupancy=0, 0x55 never emitted.
- Random: random in_valid/out_ready (50%) for 10k cycles in both SKID_EN settings -> scoreboard shows order preserved, no loss/dup, out_data stable whenever out_valid & !out_ready.
- SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle. out_ready=1 with in_valid=1 -> in_ready=1 combinationally and a new payload is loaded the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: FSM encoding, occupancy width, RV32 NOP.
package pipe_pkg;

  localparam int OCC_W = 2;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Bit 0 is main-valid, bit 1 is skid-valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      EMPTY:   return 2'd0;
      BUSY:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; async reset to RESET_VALUE, synchronous clear to FLUSH_VALUE.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= RESET_VALUE;
    else if (clear) q <= FLUSH_VALUE;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready on both sides, synchronous flush and optional
// 2-entry skid buffer that makes in_ready a flop output.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
  parameter bit               SKID_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  state_t           state_p0, state_nx;
  logic             rdy_p0;
  logic             rdy_comb;
  logic             main_ld, skid_ld;
  logic [WIDTH-1:0] main_d, skid_q;

  assign out_valid = state_p0[0];
  assign occupancy = occ_of(state_p0);
  assign rdy_comb  = !out_valid || out_ready;
  assign in_ready  = SKID_EN ? rdy_p0 : rdy_comb;

  always_comb begin
    state_nx = state_p0;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    main_d   = in_data;
    if (flush) begin
      state_nx = EMPTY;
    end else if (SKID_EN) begin
      case (state_p0)
        EMPTY: begin
          if (in_valid) begin
            main_ld  = 1'b1;
            state_nx = BUSY;
          end
        end
        BUSY: begin
          if (out_ready) begin
            if (in_valid) main_ld  = 1'b1;
            else          state_nx = EMPTY;
          end else if (in_valid) begin
            skid_ld  = 1'b1;
            state_nx = FULL;
          end
        end
        default: begin
          // FULL: input side is closed, drain skid into main when downstream takes
          if (out_ready) begin
            main_ld  = 1'b1;
            main_d   = skid_q;
            state_nx = BUSY;
          end
        end
      endcase
    end else begin
      if (in_valid && rdy_comb) begin
        main_ld  = 1'b1;
        state_nx = BUSY;
      end else if (out_valid && out_ready) begin
        state_nx = EMPTY;
      end
    end
  end

  // Stage p0: control state and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
      rdy_p0   <= 1'b1;
    end else begin
      state_p0 <= state_nx;
      rdy_p0   <= (state_nx != FULL);
    end
  end

  pipe_data_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .FLUSH_VALUE (FLUSH_VALUE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (main_ld),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .FLUSH_VALUE (FLUSH_VALUE)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (skid_ld),
        .d     (in_data),
        .q     (skid_q)
      );
    end else begin : g_noskid
      assign skid_q = '0;
    end
  endgenerate

endmodule
